bram_read_arbiter: RTL and testbench
====================================

// Module: bram_read_arbiter
// PURPOSE
//  Shares one single-port image block-memory read port (title/pokemon/alphabet ROMs) between up to NUM_REQ
//  pixel fetchers (scene renderers, sprite/text overlays), replacing the static scene_state address mux.
//  Round-robin arbitration, registered grant/address, fixed-latency read return tagged to the requester.
//  Sits between the scene renderers and the ROM instance in top.
// PARAMETERS
//  NUM_REQ  4   number of requesters (2..8)
//  ADDR_W   17  ROM address width
//  DATA_W   12  ROM data width (RGB444)
//  RD_LAT   2   cycles from mem_en/mem_addr cycle to valid mem_dout (1..3)
// PORTS
//  clk       in   1               system clock; all logic on rising edge
//  rst       in   1               synchronous, active-low reset
//  flush     in   1               drop all in-flight reads (scene change)
//  req       in   NUM_REQ         per-requester read request, level
//  req_addr  in   NUM_REQ*ADDR_W  requester i address at [i*ADDR_W +: ADDR_W]
//  gnt       out  NUM_REQ         one-hot (or zero) grant, registered
//  mem_en    out  1               ROM read enable, registered
//  mem_addr  out  ADDR_W          ROM address, registered
//  mem_dout  in   DATA_W          ROM read data, valid RD_LAT cycles after mem_en
//  rd_valid  out  NUM_REQ         one-hot: rd_data belongs to this requester this cycle
//  rd_data   out  DATA_W          returned pixel data
// BEHAVIOUR
//  Reset (rst==0 at edge): gnt=0, mem_en=0, mem_addr=0, rd_valid=0, rd_data=0, tag pipe cleared,
//   rr pointer last=NUM_REQ-1 (req[0] highest priority first). In-flight reads are discarded.
//  Arbitration each edge: eligible = req & ~gnt (requester granted this cycle is masked).
//   Winner = first set bit of eligible searching last+1, last+2, ... wrapping mod NUM_REQ.
//   If winner exists: gnt<=onehot(winner), mem_en<=1, mem_addr<=req_addr[winner], last<=winner.
//   Else: gnt<=0, mem_en<=0, mem_addr holds, last holds.
//  Handshake: requester holds req and req_addr stable until it sees gnt[i]=1; dropping req at the end
//   of the gnt cycle gives exactly one read. Keeping req high = new read (earliest 2 cycles after prior gnt).
//  At most one grant per cycle; back-to-back grants to different requesters every cycle (full throughput).
//  Return: tag pipe of RD_LAT stages carries gnt one-hot. rd_valid = tag at stage RD_LAT, and
//   rd_data = mem_dout in that same cycle (combinational pass, no extra register); rd_data = 0 when rd_valid==0.
//   Net latency: gnt/mem_en cycle t -> rd_valid cycle t+RD_LAT.
//  flush=1 at edge: clears all tag stages and forces gnt=0/mem_en=0 that edge; rr pointer kept;
//   no rd_valid for any read granted at or before the flush edge. Arbitration resumes next edge.
//  flush and rst together: rst wins. req to an out-of-range bit is impossible (width = NUM_REQ).
//  No starvation: any held request is granted within NUM_REQ cycles.
// TESTING
//  1 rst=0 two cycles with all req=1 -> gnt=0, mem_en=0, mem_addr=0, rd_valid=0 throughout.
//  2 Single req[1], addr 17'h00123 -> next cycle gnt=4'b0010, mem_addr=17'h00123; 2 cycles later
//    rd_valid=4'b0010, rd_data=ROM[0x123]; exactly one read.
//  3 req=4'b1111 same cycle, each drops on its gnt -> gnt 0001,0010,0100,1000 on consecutive cycles;
//    rd_valid same order offset by 2; data matches each address.
//  4 req[0] and req[2] held high continuously -> gnt alternates 0001,0100,0001,0100; neither starved.
//  5 flush pulsed the cycle after a gnt to req[3] -> no rd_valid[3] for that read; a new req[3]
//    after flush returns data normally with latency 2.
//  6 rst=0 asserted with 2 reads in flight -> no rd_valid for them; after release req[0] granted first.

Source files
------------

// File: rtl/bram_read_arbiter_if.sv
// Fetcher/ROM-side bundle of the image BRAM read arbiter.
// slave = arbiter view; master = pixel fetchers together with the ROM instance.
interface bram_read_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 17,
    parameter int DATA_W  = 12
);
    logic                      flush;
    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ-1:0]        gnt;
    logic                      mem_en;
    logic [ADDR_W-1:0]         mem_addr;
    logic [DATA_W-1:0]         mem_dout;
    logic [NUM_REQ-1:0]        rd_valid;
    logic [DATA_W-1:0]         rd_data;

    modport slave (
        input  flush, req, req_addr, mem_dout,
        output gnt, mem_en, mem_addr, rd_valid, rd_data
    );

    modport master (
        output flush, req, req_addr, mem_dout,
        input  gnt, mem_en, mem_addr, rd_valid, rd_data
    );
endinterface

// File: rtl/bram_read_arbiter.sv
// Round-robin share of one single-port image ROM read port among NUM_REQ pixel fetchers.
// Latency: gnt/mem_addr registered one edge after req; rd_valid/rd_data RD_LAT cycles after gnt.
// Backpressure: none on return; a fetcher waits by holding req/req_addr until it sees its gnt bit.
module bram_read_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 17,
    parameter int DATA_W  = 12,
    parameter int RD_LAT  = 2
) (
    input  logic               clk,
    input  logic               rst,
    bram_read_arbiter_if.slave bus
);
    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0] gnt_q;
    logic               mem_en_q;
    logic [ADDR_W-1:0]  mem_addr_q;
    logic [IDX_W-1:0]   last_q;
    logic [NUM_REQ-1:0] tag_q [RD_LAT];

    logic [NUM_REQ-1:0] eligible;
    logic               win_vld;
    logic [IDX_W-1:0]   win_idx;
    logic [NUM_REQ-1:0] win_onehot;
    logic [ADDR_W-1:0]  win_addr;

    // The requester holding this cycle's grant is masked so it cannot win twice in a row.
    assign eligible = bus.req & ~gnt_q;

    always_comb begin
        int cand;
        cand    = 0;
        win_vld = 1'b0;
        win_idx = last_q;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = (int'(last_q) + k) % NUM_REQ;
            if (!win_vld && eligible[IDX_W'(cand)]) begin
                win_vld = 1'b1;
                win_idx = IDX_W'(cand);
            end
        end
    end

    always_comb begin
        win_onehot = '0;
        win_addr   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (win_idx == IDX_W'(i)) begin
                win_onehot[i] = 1'b1;
                win_addr      = bus.req_addr[i*ADDR_W +: ADDR_W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            gnt_q      <= '0;
            mem_en_q   <= 1'b0;
            mem_addr_q <= '0;
            last_q     <= IDX_W'(NUM_REQ - 1);
            for (int s = 0; s < RD_LAT; s++) tag_q[s] <= '0;
        end else if (bus.flush) begin
            // Scene change: abandon every read still in the pipe, keep fairness state.
            gnt_q    <= '0;
            mem_en_q <= 1'b0;
            for (int s = 0; s < RD_LAT; s++) tag_q[s] <= '0;
        end else begin
            tag_q[0] <= gnt_q;
            for (int s = 1; s < RD_LAT; s++) tag_q[s] <= tag_q[s-1];
            if (win_vld) begin
                gnt_q      <= win_onehot;
                mem_en_q   <= 1'b1;
                mem_addr_q <= win_addr;
                last_q     <= win_idx;
            end else begin
                gnt_q    <= '0;
                mem_en_q <= 1'b0;
            end
        end
    end

    assign bus.gnt      = gnt_q;
    assign bus.mem_en   = mem_en_q;
    assign bus.mem_addr = mem_addr_q;
    assign bus.rd_valid = tag_q[RD_LAT-1];
    assign bus.rd_data  = (|tag_q[RD_LAT-1]) ? bus.mem_dout : '0;
endmodule

// File: tb/tb_bram_read_arbiter.sv
// Randomised scoreboard bench for bram_read_arbiter with a ROM model and directed scenarios.
module tb_bram_read_arbiter;
    localparam int NUM_REQ = 4;
    localparam int ADDR_W  = 17;
    localparam int DATA_W  = 12;
    localparam int RD_LAT  = 2;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    bram_read_arbiter_if #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    bram_read_arbiter #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct { int cyc; logic [NUM_REQ-1:0] gnt; logic en; logic [ADDR_W-1:0] addr; } gexp_t;
    typedef struct { int cyc; logic [NUM_REQ-1:0] vld; logic [DATA_W-1:0] data; } rexp_t;
    typedef struct { int ret; logic [NUM_REQ-1:0] who; logic [DATA_W-1:0] data; } fly_t;

    gexp_t gq[$];
    rexp_t rq[$];
    fly_t  inflight[$];

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    logic [NUM_REQ-1:0] r_req = '0;
    logic [ADDR_W-1:0]  r_addr [NUM_REQ] = '{default: '0};
    bit                 keep   [NUM_REQ] = '{default: 1'b0};

    // Reference state: who is granted in the current cycle, fairness pointer, last issued address.
    logic [NUM_REQ-1:0] m_gnt  = '0;
    int                 m_last = NUM_REQ - 1;
    logic [ADDR_W-1:0]  m_addr = '0;

    logic [ADDR_W-1:0] addr_d [RD_LAT] = '{default: '0};

    function automatic logic [DATA_W-1:0] rom(input logic [ADDR_W-1:0] a);
        return DATA_W'(a * 17'd3) ^ 12'h5A5;
    endfunction

    // ROM: data for the address presented in cycle t appears in cycle t+RD_LAT.
    always @(posedge clk) begin
        cyc       <= cyc + 1;
        addr_d[0] <= bus.mem_addr;
        for (int k = 1; k < RD_LAT; k++) addr_d[k] <= addr_d[k-1];
    end
    assign bus.mem_dout = rom(addr_d[RD_LAT-1]);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
        end
    endtask

    // Drive one cycle of inputs, predict the outputs of the next cycle, advance to its negedge.
    task automatic step(input bit rst_v, input bit flush_v);
        logic [NUM_REQ-1:0] elig;
        int    w;
        int    idx;
        fly_t  f;
        rexp_t r;
        rst      = rst_v;
        bus.flush = flush_v;
        bus.req  = r_req;
        for (int i = 0; i < NUM_REQ; i++) bus.req_addr[i*ADDR_W +: ADDR_W] = r_addr[i];

        if (!rst_v) begin
            m_gnt  = '0;
            m_last = NUM_REQ - 1;
            m_addr = '0;
            inflight.delete();
        end else if (flush_v) begin
            m_gnt = '0;
            inflight.delete();
        end else begin
            elig = r_req & ~m_gnt;
            w = -1;
            for (int k = 1; k <= NUM_REQ; k++) begin
                idx = (m_last + k) % NUM_REQ;
                if (w < 0 && elig[idx]) w = idx;
            end
            m_gnt = '0;
            if (w >= 0) begin
                m_gnt[w] = 1'b1;
                m_last   = w;
                m_addr   = r_addr[w];
                f.ret  = cyc + 1 + RD_LAT;
                f.who  = m_gnt;
                f.data = rom(r_addr[w]);
                inflight.push_back(f);
            end
        end
        gq.push_back('{cyc + 1, m_gnt, |m_gnt, m_addr});

        r = '{cyc + 1, '0, '0};
        if (inflight.size() > 0 && inflight[0].ret == cyc + 1) begin
            f = inflight.pop_front();
            r.vld  = f.who;
            r.data = f.data;
        end
        rq.push_back(r);

        @(posedge clk);
        @(negedge clk);
        // Fetchers see their grant now: drop, or keep requesting with a fresh address.
        for (int i = 0; i < NUM_REQ; i++) begin
            if (m_gnt[i]) begin
                if (keep[i]) r_addr[i] = ADDR_W'($urandom);
                else         r_req[i]  = 1'b0;
            end
        end
    endtask

    always @(negedge clk) begin
        gexp_t g;
        rexp_t r;
        while (gq.size() > 0 && gq[0].cyc < cyc) begin
            g = gq.pop_front();
            check("gnt_missed", 32'(cyc), 32'(g.cyc));
        end
        if (gq.size() > 0 && gq[0].cyc == cyc) begin
            g = gq.pop_front();
            check("gnt",      32'(bus.gnt),      32'(g.gnt));
            check("mem_en",   32'(bus.mem_en),   32'(g.en));
            check("mem_addr", 32'(bus.mem_addr), 32'(g.addr));
        end
        while (rq.size() > 0 && rq[0].cyc < cyc) begin
            r = rq.pop_front();
            check("rd_missed", 32'(cyc), 32'(r.cyc));
        end
        if (rq.size() > 0 && rq[0].cyc == cyc) begin
            r = rq.pop_front();
            check("rd_valid", 32'(bus.rd_valid), 32'(r.vld));
            check("rd_data",  32'(bus.rd_data),  32'(r.data));
        end
    end

    initial begin
        bus.flush    = 1'b0;
        bus.req      = '0;
        bus.req_addr = '0;
        @(negedge clk);

        // Reset held with every fetcher requesting: nothing may be granted.
        r_req = '1;
        step(0, 0);
        step(0, 0);
        r_req = '0;
        step(1, 0);

        // Single fetch from requester 1.
        r_addr[1] = 17'h00123;
        r_req     = 4'b0010;
        repeat (5) step(1, 0);

        // Fresh pointer, then all four at once: grants in index order.
        step(0, 0);
        for (int i = 0; i < NUM_REQ; i++) r_addr[i] = ADDR_W'(17'h01000 + i * 17'h111);
        r_req = '1;
        repeat (7) step(1, 0);

        // Two continuous requesters alternate.
        keep[0] = 1'b1;
        keep[2] = 1'b1;
        r_req   = 4'b0101;
        repeat (8) step(1, 0);
        keep[0] = 1'b0;
        keep[2] = 1'b0;
        r_req   = '0;
        repeat (3) step(1, 0);

        // Flush kills an in-flight read; the next read returns normally.
        r_addr[3] = 17'h1ABCD;
        r_req     = 4'b1000;
        step(1, 0);
        step(1, 0);
        step(1, 1);
        step(1, 0);
        r_addr[3] = 17'h00ACE;
        r_req     = 4'b1000;
        repeat (5) step(1, 0);

        // Reset with two reads in flight, then requester 0 must win first.
        r_addr[1] = 17'h00777;
        r_addr[2] = 17'h00888;
        r_req     = 4'b0110;
        step(1, 0);
        step(1, 0);
        r_req = '1;
        step(0, 0);
        repeat (8) step(1, 0);

        // Random traffic with occasional flush and reset.
        for (int n = 0; n < 3000; n++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!r_req[i] && $urandom_range(3) == 0) begin
                    r_req[i]  = 1'b1;
                    r_addr[i] = ADDR_W'($urandom);
                end
                keep[i] = ($urandom_range(2) == 0);
            end
            step(($urandom_range(199) != 0), ($urandom_range(31) == 0));
        end

        r_req = '0;
        repeat (RD_LAT + 2) step(1, 0);
        repeat (3) @(negedge clk);
        check("gq_drained", 32'(gq.size()), 32'd0);
        check("rq_drained", 32'(rq.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
